// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch, CDB, operand-lookup and commit signals of the reorder buffer.
interface reorder_buffer_if #(
    parameter int ROB_TAG_LEN = 4,
    parameter int XLEN        = 32
);
    logic                   squash;
    logic                   dispatch_valid;
    logic [4:0]             dispatch_rd;
    logic                   dispatch_ready;
    logic [ROB_TAG_LEN-1:0] dispatch_tag;
    logic                   cdb_valid;
    logic [ROB_TAG_LEN-1:0] cdb_tag;
    logic [XLEN-1:0]        cdb_value;
    logic [ROB_TAG_LEN-1:0] rs1_tag, rs2_tag;
    logic                   rs1_ready, rs2_ready;
    logic [XLEN-1:0]        rs1_value, rs2_value;
    logic                   commit;
    logic [4:0]             rd_commit;
    logic [ROB_TAG_LEN-1:0] commit_tag;
    logic [XLEN-1:0]        commit_value;
    logic                   rob_empty;

    modport master (
        output squash, dispatch_valid, dispatch_rd, cdb_valid, cdb_tag, cdb_value, rs1_tag, rs2_tag,
        input  dispatch_ready, dispatch_tag, rs1_ready, rs2_ready, rs1_value, rs2_value,
               commit, rd_commit, commit_tag, commit_value, rob_empty
    );
    modport slave (
        input  squash, dispatch_valid, dispatch_rd, cdb_valid, cdb_tag, cdb_value, rs1_tag, rs2_tag,
        output dispatch_ready, dispatch_tag, rs1_ready, rs2_ready, rs1_value, rs2_value,
               commit, rd_commit, commit_tag, commit_value, rob_empty
    );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order ROB; allocates tags, marks completion from the CDB,
// retires the head in program order and serves operand values by tag (tag 0 = no producer).
module reorder_buffer #(
    parameter int ROB_DEPTH   = 8,
    parameter int ROB_TAG_LEN = 4,
    parameter int XLEN        = 32
) (
    input logic             clock,
    input logic             reset,
    reorder_buffer_if.slave rob
);
    localparam int IW = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
    typedef logic [ROB_TAG_LEN-1:0] tag_t;
    typedef logic [IW-1:0] idx_t;
    localparam tag_t DEPTH = tag_t'(ROB_DEPTH);
    localparam tag_t ONE   = tag_t'(1);
    localparam idx_t LAST  = idx_t'(ROB_DEPTH - 1);

    logic [ROB_DEPTH-1:0] valid, done;
    logic [4:0]           rd    [ROB_DEPTH];
    logic [XLEN-1:0]      value [ROB_DEPTH];
    idx_t                 head, tail;
    tag_t                 count;
    logic                 alloc, cdb_hit;

    function automatic idx_t idx(input tag_t t);
        return idx_t'(t - ONE);
    endfunction

    function automatic logic in_range(input tag_t t);
        return t != '0 && t <= DEPTH;
    endfunction

    function automatic idx_t nxt(input idx_t p);
        return p == LAST ? '0 : p + idx_t'(1);
    endfunction

    // A matching CDB broadcast wins over storage so dispatch sees results a cycle early.
    function automatic logic [XLEN:0] lookup(input tag_t t, input logic cv, input tag_t ct,
                                             input logic [XLEN-1:0] cval);
        idx_t i;
        i = idx(t);
        if (!in_range(t)) return '0;
        if (cv && ct == t) return {1'b1, cval};
        return (valid[i] && done[i]) ? {1'b1, value[i]} : '0;
    endfunction

    always_comb begin
        rob.dispatch_ready = count < DEPTH;
        rob.dispatch_tag   = tag_t'(tail) + ONE;
        alloc              = rob.dispatch_valid && rob.dispatch_ready;
        rob.commit         = valid[head] && done[head] && !rob.squash;
        rob.rd_commit      = rd[head];
        rob.commit_tag     = tag_t'(head) + ONE;
        rob.commit_value   = value[head];
        rob.rob_empty      = count == '0;
        cdb_hit            = rob.cdb_valid && in_range(rob.cdb_tag) && valid[idx(rob.cdb_tag)];
        {rob.rs1_ready, rob.rs1_value} = lookup(rob.rs1_tag, rob.cdb_valid, rob.cdb_tag, rob.cdb_value);
        {rob.rs2_ready, rob.rs2_value} = lookup(rob.rs2_tag, rob.cdb_valid, rob.cdb_tag, rob.cdb_value);
    end

    // Head and tail only coincide when empty or full, so alloc and retire never touch the same slot.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rd[i]    <= '0;
                value[i] <= '0;
            end
        end else if (rob.squash) begin
            valid <= '0;
            done  <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (cdb_hit) begin
                done[idx(rob.cdb_tag)]  <= 1'b1;
                value[idx(rob.cdb_tag)] <= rob.cdb_value;
            end
            if (rob.commit) begin
                valid[head] <= 1'b0;
                head        <= nxt(head);
            end
            if (alloc) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
                rd[tail]    <= rob.dispatch_rd;
                value[tail] <= '0;
                tail        <= nxt(tail);
            end
            count <= count + tag_t'(alloc) - tag_t'(rob.commit);
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: scoreboard of expected retirements plus a lookup vector table
// and hand-written sequences for reset, wrap, bypass, squash and rd=0 corner cases.
`timescale 1ns/100ps
module tb_reorder_buffer;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #10 clock = ~clock;

    reorder_buffer_if #(.ROB_TAG_LEN(4), .XLEN(32)) ifc ();
    reorder_buffer #(.ROB_DEPTH(8), .ROB_TAG_LEN(4), .XLEN(32)) dut (
        .clock(clock),
        .reset(reset),
        .rob  (ifc.slave)
    );

    typedef struct {
        logic [4:0] rd;
        logic [3:0] tag;
    } exp_t;

    typedef struct {
        logic [3:0]  tag;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic        er;
        logic [31:0] ev;
    } vec_t;

    exp_t        sbq[$];
    logic [31:0] mval [16];
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (ifc.commit === 1'b1) begin
            tests++;
            if (sbq.size() == 0) begin
                fails++;
                $display("FAIL commit_unexpected: got tag %0d rd %0d, want no commit", ifc.commit_tag, ifc.rd_commit);
            end else begin
                e = sbq.pop_front();
                if (ifc.rd_commit !== e.rd || ifc.commit_tag !== e.tag || ifc.commit_value !== mval[e.tag]) begin
                    fails++;
                    $display("FAIL commit_order: got rd %0d tag %0d val 0x%0h, want rd %0d tag %0d val 0x%0h",
                             ifc.rd_commit, ifc.commit_tag, ifc.commit_value, e.rd, e.tag, mval[e.tag]);
                end
            end
        end
    end

    task automatic idle();
        ifc.squash = 0; ifc.dispatch_valid = 0; ifc.dispatch_rd = 0;
        ifc.cdb_valid = 0; ifc.cdb_tag = 0; ifc.cdb_value = 0;
        ifc.rs1_tag = 0; ifc.rs2_tag = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic dispatch(input logic [4:0] r, input logic [3:0] t);
        ifc.dispatch_valid = 1; ifc.dispatch_rd = r;
        @(negedge clock);
        chk("dispatch_ready", ifc.dispatch_ready, 1);
        chk("dispatch_tag", ifc.dispatch_tag, t);
        sbq.push_back('{r, t});
        tick();
    endtask

    task automatic complete(input logic [3:0] t, input logic [31:0] v);
        ifc.cdb_valid = 1; ifc.cdb_tag = t; ifc.cdb_value = v;
        mval[t] = v;
        tick();
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 40 && ifc.rob_empty !== 1'b1; i++) tick();
        chk("drain_empty", ifc.rob_empty, 1);
    endtask

    task automatic do_reset();
        #2 reset = 0;
        sbq.delete();
        @(negedge clock);
        chk("rst_tag", ifc.dispatch_tag, 1);
        chk("rst_empty", ifc.rob_empty, 1);
        chk("rst_commit", ifc.commit, 0);
        @(posedge clock);
        #1 reset = 1;
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[10];
        vt[0] = '{4'd0, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0};
        vt[1] = '{4'd4, 1'b0, 4'd0, 32'h0,    1'b1, 32'hDEADBEEF};
        vt[2] = '{4'd1, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0};
        vt[3] = '{4'd1, 1'b1, 4'd1, 32'h1234, 1'b1, 32'h1234};
        vt[4] = '{4'd2, 1'b1, 4'd1, 32'h1234, 1'b0, 32'h0};
        vt[5] = '{4'd9, 1'b1, 4'd9, 32'h55,   1'b0, 32'h0};
        vt[6] = '{4'd6, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0};
        vt[7] = '{4'd6, 1'b1, 4'd6, 32'h77,   1'b1, 32'h77};
        vt[8] = '{4'd0, 1'b1, 4'd0, 32'h99,   1'b0, 32'h0};
        vt[9] = '{4'd8, 1'b0, 4'd0, 32'h0,    1'b0, 32'h0};
        idle();
        ifc.rs1_tag = 1;
        repeat (2) @(negedge clock);
        chk("reset_ready", ifc.dispatch_ready, 1);
        chk("reset_tag", ifc.dispatch_tag, 1);
        chk("reset_commit", ifc.commit, 0);
        chk("reset_rd_commit", ifc.rd_commit, 0);
        chk("reset_commit_tag", ifc.commit_tag, 1);
        chk("reset_commit_value", ifc.commit_value, 0);
        chk("reset_rs1_ready", ifc.rs1_ready, 0);
        chk("reset_rs1_value", ifc.rs1_value, 0);
        chk("reset_empty", ifc.rob_empty, 1);
        @(posedge clock);
        #1 reset = 1;
        idle();

        // mid-stream reset discards three live entries, two of them done
        dispatch(1, 1); dispatch(2, 2); dispatch(3, 3);
        complete(2, 32'h22); complete(3, 32'h33);
        do_reset();
        complete(1, 32'h11);
        repeat (3) tick();
        ifc.rs1_tag = 2;
        @(negedge clock);
        chk("post_reset_rs1", ifc.rs1_ready, 0);
        chk("post_reset_empty", ifc.rob_empty, 1);
        chk("post_reset_tag", ifc.dispatch_tag, 1);
        tick();

        // out-of-order completion, in-order retirement
        dispatch(5, 1); dispatch(6, 2); dispatch(7, 3);
        complete(3, 32'h333); complete(1, 32'h111);
        @(negedge clock);
        chk("t2_commit_tag1", ifc.commit, 1);
        chk("t2_rd_5", ifc.rd_commit, 5);
        tick();
        ifc.cdb_valid = 1; ifc.cdb_tag = 2; ifc.cdb_value = 32'h222; mval[2] = 32'h222;
        @(negedge clock);
        chk("t2_cdb_head_no_commit", ifc.commit, 0);
        tick();
        @(negedge clock);
        chk("t2_commit_tag2", ifc.commit_tag, 2);
        tick();
        @(negedge clock);
        chk("t2_commit_rd7", ifc.rd_commit, 7);
        tick();
        chk("t2_empty", ifc.rob_empty, 1);

        // full buffer and tail wrap
        do_reset();
        for (int i = 0; i < 8; i++) dispatch(5'(i + 10), 4'(i + 1));
        @(negedge clock);
        chk("full_ready", ifc.dispatch_ready, 0);
        chk("full_tag", ifc.dispatch_tag, 1);
        ifc.dispatch_valid = 1; ifc.dispatch_rd = 20;
        ifc.cdb_valid = 1; ifc.cdb_tag = 1; ifc.cdb_value = 32'hA1; mval[1] = 32'hA1;
        tick();
        ifc.dispatch_valid = 1; ifc.dispatch_rd = 21;
        @(negedge clock);
        chk("full_commit", ifc.commit, 1);
        chk("full_no_reuse", ifc.dispatch_ready, 0);
        tick();
        dispatch(21, 1);
        for (int t = 2; t <= 8; t++) complete(4'(t), 32'h100 + 32'(t));
        complete(1, 32'hB1);
        wait_empty();

        // CDB bypass then storage, then lookup table
        do_reset();
        for (int i = 1; i <= 4; i++) dispatch(5'(i), 4'(i));
        ifc.rs1_tag = 4; ifc.rs2_tag = 4;
        ifc.cdb_valid = 1; ifc.cdb_tag = 4; ifc.cdb_value = 32'hDEADBEEF; mval[4] = 32'hDEADBEEF;
        @(negedge clock);
        chk("byp_rs1_ready", ifc.rs1_ready, 1);
        chk("byp_rs1_value", ifc.rs1_value, 32'hDEADBEEF);
        chk("byp_rs2_value", ifc.rs2_value, 32'hDEADBEEF);
        tick();
        ifc.rs1_tag = 4;
        @(negedge clock);
        chk("store_rs1_ready", ifc.rs1_ready, 1);
        chk("store_rs1_value", ifc.rs1_value, 32'hDEADBEEF);
        for (int i = 0; i < 10; i++) begin
            ifc.rs1_tag = vt[i].tag; ifc.rs2_tag = vt[i].tag;
            ifc.cdb_valid = vt[i].cv; ifc.cdb_tag = vt[i].ct; ifc.cdb_value = vt[i].cval;
            #0.5;
            chk($sformatf("lut%0d_rs1_ready", i), ifc.rs1_ready, vt[i].er);
            chk($sformatf("lut%0d_rs1_value", i), ifc.rs1_value, vt[i].ev);
            chk($sformatf("lut%0d_rs2_ready", i), ifc.rs2_ready, vt[i].er);
            chk($sformatf("lut%0d_rs2_value", i), ifc.rs2_value, vt[i].ev);
        end
        idle();
        tick();

        // squash with a retire-ready head, CDB and dispatch in the same cycle
        dispatch(9, 5);
        complete(1, 32'h111);
        ifc.squash = 1; ifc.dispatch_valid = 1; ifc.dispatch_rd = 9;
        ifc.cdb_valid = 1; ifc.cdb_tag = 2; ifc.cdb_value = 32'h222;
        @(negedge clock);
        chk("squash_commit_forced", ifc.commit, 0);
        sbq.delete();
        tick();
        @(negedge clock);
        chk("squash_empty", ifc.rob_empty, 1);
        chk("squash_tag", ifc.dispatch_tag, 1);
        chk("squash_ready", ifc.dispatch_ready, 1);
        tick();
        complete(2, 32'h999);
        ifc.rs1_tag = 2;
        @(negedge clock);
        chk("late_cdb_rs1", ifc.rs1_ready, 0);
        chk("late_cdb_empty", ifc.rob_empty, 1);
        tick();

        // rd=0 retirement, then retire and allocate together
        dispatch(0, 1);
        complete(1, 32'h42);
        @(negedge clock);
        chk("rd0_commit", ifc.commit, 1);
        chk("rd0_rd", ifc.rd_commit, 0);
        tick();
        chk("rd0_empty", ifc.rob_empty, 1);
        dispatch(4, 2);
        complete(2, 32'h55);
        ifc.dispatch_valid = 1; ifc.dispatch_rd = 3;
        @(negedge clock);
        chk("both_commit", ifc.commit, 1);
        chk("both_tag", ifc.dispatch_tag, 3);
        sbq.push_back('{5'd3, 4'd3});
        tick();
        chk("both_count_kept", ifc.rob_empty, 0);
        complete(3, 32'h66);
        wait_empty();

        chk("scoreboard_drained", 64'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
